// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage: radix-2 shift-add multiply and restoring divide.
// Optional single-cycle multiplier selected by defining MD_FAST_MUL_EN; divides always iterate.
module execute_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            Start_E,
  input  logic [2:0]      MD_Op_E,
  input  logic [XLEN-1:0] Src_A_E,
  input  logic [XLEN-1:0] Src_B_E,
  input  logic            Flush_E,
  output logic            Stall_MD,
  output logic            Busy_E,
  output logic            Done_E,
  output logic [XLEN-1:0] Result_E
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        op_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [XLEN-1:0]   result_reg;

  logic              is_div;
  logic              sign_a;
  logic              sign_b;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;

  // Operand decode for the instruction waiting in execute
  always_comb begin
    is_div   = MD_Op_E[2];
    sign_a   = (MD_Op_E == 3'd1) | (MD_Op_E == 3'd2) | (MD_Op_E == 3'd4) | (MD_Op_E == 3'd6);
    sign_b   = (MD_Op_E == 3'd1) | (MD_Op_E == 3'd4) | (MD_Op_E == 3'd6);
    a_neg    = sign_a & Src_A_E[XLEN-1];
    b_neg    = sign_b & Src_B_E[XLEN-1];
    a_mag    = a_neg ? -Src_A_E : Src_A_E;
    b_mag    = b_neg ? -Src_B_E : Src_B_E;
    div_zero = is_div & (Src_B_E == '0);
    div_ovf  = ((MD_Op_E == 3'd4) | (MD_Op_E == 3'd6)) &
               (Src_A_E == {1'b1, {(XLEN-1){1'b0}}}) & (Src_B_E == '1);
    if (div_zero)
      special_res = MD_Op_E[1] ? Src_A_E : '1;
    else
      special_res = MD_Op_E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef MD_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a;
  logic signed [XLEN:0]     fast_b;
  logic signed [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]          fast_res;

  // 33x33 signed product; the extra bit carries each operand's signedness
  always_comb begin
    fast_a    = {sign_a & Src_A_E[XLEN-1], Src_A_E};
    fast_b    = {sign_b & Src_B_E[XLEN-1], Src_B_E};
    fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
    fast_res  = (MD_Op_E == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  logic [XLEN:0]     mul_hi;
  logic [XLEN:0]     rem_shift;
  logic              rem_fits;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;

  // acc_reg holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_hi    = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, (acc_reg[0] ? opnd_reg : {XLEN{1'b0}})};
    rem_shift = acc_reg[2*XLEN-1:XLEN-1];
    rem_fits  = rem_shift >= {1'b0, opnd_reg};
    rem_sub   = rem_shift[XLEN-1:0] - opnd_reg;
    if (op_reg[2])
      acc_step = {(rem_fits ? rem_sub : rem_shift[XLEN-1:0]), acc_reg[XLEN-2:0], rem_fits};
    else
      acc_step = {mul_hi, acc_reg[XLEN-1:1]};

    prod_fix = neg_q_reg ? -acc_step : acc_step;
    quot_fix = neg_q_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = neg_r_reg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_reg)
      3'd0:          final_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: final_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    final_res = quot_fix;
      default:       final_res = rem_fix;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else if (Flush_E) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start_E) begin
            op_reg    <= MD_Op_E;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            cnt_reg   <= CNT_W'(XLEN-1);
            if (div_zero | div_ovf) begin
              result_reg <= special_res;
              done_reg   <= 1'b1;
              state_reg  <= DONE;
            end
`ifdef MD_FAST_MUL_EN
            else if (!is_div) begin
              result_reg <= fast_res;
              done_reg   <= 1'b1;
              state_reg  <= DONE;
            end
`endif
            else begin
              opnd_reg  <= is_div ? b_mag : a_mag;
              acc_reg   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              busy_reg  <= 1'b1;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          acc_reg <= acc_step;
          if (cnt_reg == '0) begin
            result_reg <= final_res;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Stall_MD = RST_N & (((state_reg == IDLE) & Start_E & ~Flush_E) | (state_reg == CALC));
  assign Busy_E   = busy_reg;
  assign Done_E   = done_reg;
  assign Result_E = result_reg;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Randomized self-checking bench for execute_muldiv_unit against an arithmetic reference model.
module tb_execute_muldiv_unit;

  logic        CLK;
  logic        RST_N;
  logic        Start_E;
  logic [2:0]  MD_Op_E;
  logic [31:0] Src_A_E;
  logic [31:0] Src_B_E;
  logic        Flush_E;
  logic        Stall_MD;
  logic        Busy_E;
  logic        Done_E;
  logic [31:0] Result_E;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res = 32'd0;
  logic        done_seen;

  execute_muldiv_unit #(.XLEN(32)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Start_E  (Start_E),
    .MD_Op_E  (MD_Op_E),
    .Src_A_E  (Src_A_E),
    .Src_B_E  (Src_B_E),
    .Flush_E  (Flush_E),
    .Stall_MD (Stall_MD),
    .Busy_E   (Busy_E),
    .Done_E   (Done_E),
    .Result_E (Result_E)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit arithmetic on sign/zero-extended operands, RISC-V corner cases handled explicitly
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, sp;
    logic [63:0] ua, uu, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    ua = {32'd0, a};
    uu = {32'd0, b};
    case (op)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * ub; return sp[63:32]; end
      3'd3: begin up = ua * uu; return up[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; sp = sa / sb; return sp[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
`ifdef MD_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge in an IDLE cycle; returns at the negedge of the DONE cycle with Start_E still high
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat, stalls, busys, want;
    want = exp_latency(op, a, b);
    Start_E = 1'b1;
    MD_Op_E = op;
    Src_A_E = a;
    Src_B_E = b;
    #1;
    stalls = int'(Stall_MD);
    busys  = 0;
    lat    = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge CLK);
      if (Done_E) lat = k;
      else begin
        stalls += int'(Stall_MD);
        busys  += int'(Busy_E);
      end
    end
    check_val("latency", 32'(lat), 32'(want));
    check_val("result", Result_E, exp);
    check_val("stall_cycles", 32'(stalls), 32'(want));
    check_val("busy_cycles", 32'(busys), (want == 33) ? 32'd32 : 32'd0);
    check_val("stall_in_done", {31'd0, Stall_MD}, 32'd0);
    $display("op=%0d a=%08h b=%08h result=%08h expect=%08h latency=%0d", op, a, b, Result_E, exp, lat);
    last_res = exp;
  endtask

  logic [2:0]  d_op  [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
  logic [31:0] d_a   [14] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
  logic [31:0] d_b   [14] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
  logic [31:0] d_exp [14] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd5};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    RST_N   = 1'b0;
    Start_E = 1'b1;
    Flush_E = 1'b0;
    MD_Op_E = 3'd4;
    Src_A_E = 32'd9;
    Src_B_E = 32'd3;
    repeat (3) @(negedge CLK);
    check_val("reset_stall", {31'd0, Stall_MD}, 32'd0);
    check_val("reset_busy", {31'd0, Busy_E}, 32'd0);
    check_val("reset_done", {31'd0, Done_E}, 32'd0);
    check_val("reset_result", Result_E, 32'd0);
    RST_N   = 1'b1;
    Start_E = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      run_op(d_op[i], d_a[i], d_b[i], d_exp[i]);
    end

    // Flush of a divide in flight, then an immediate restart
    @(negedge CLK);
    Start_E = 1'b1; MD_Op_E = 3'd4; Src_A_E = 32'd1000; Src_B_E = 32'd3;
    done_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      done_seen = done_seen | Done_E;
    end
    Flush_E = 1'b1;
    @(negedge CLK);
    Flush_E = 1'b0;
    check_val("flush_no_done", {31'd0, done_seen | Done_E}, 32'd0);
    check_val("flush_busy", {31'd0, Busy_E}, 32'd0);
    check_val("flush_result_hold", Result_E, last_res);
    run_op(3'd5, 32'd1000, 32'd3, 32'd333);

    // Reset in the middle of a divide
    @(negedge CLK);
    Start_E = 1'b1; MD_Op_E = 3'd5; Src_A_E = 32'hDEADBEEF; Src_B_E = 32'd17;
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_val("rst_stall_low", {31'd0, Stall_MD}, 32'd0);
    @(negedge CLK);
    check_val("rst_busy", {31'd0, Busy_E}, 32'd0);
    check_val("rst_done", {31'd0, Done_E}, 32'd0);
    check_val("rst_result", Result_E, 32'd0);
    RST_N   = 1'b1;
    Start_E = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      done_seen = done_seen | Done_E;
    end
    check_val("rst_no_done", {31'd0, done_seen}, 32'd0);
    last_res = 32'd0;
    @(negedge CLK);
    run_op(3'd6, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE);

    // Random operations, mostly back-to-back with occasional idle gaps
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 3) == 0) begin
        Start_E = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
      end
      op = 3'($urandom_range(0, 7));
      a  = rand_opnd();
      b  = rand_opnd();
      run_op(op, a, b, model(op, a, b));
    end

    @(negedge CLK);
    Start_E = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
